// File: rtl/mem_access_unit_pkg.sv
// Shared types and lane helpers for the load/store access unit.
package mem_access_unit_pkg;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = DW / 8;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Fields of an accepted request needed after the accept cycle.
  typedef struct packed {
    logic       we;
    size_e      size;
    logic       sext;
    logic [1:0] off;
  } req_s;

  function automatic logic bad_req(size_e size, logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [BEW-1:0] lane_be(size_e size, logic [1:0] off);
    case (size)
      SIZE_B:  return BEW'(4'b0001 << off);
      SIZE_H:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] lane_wdata(size_e size, logic [DW-1:0] d);
    case (size)
      SIZE_B:  return {4{d[7:0]}};
      SIZE_H:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Extracts the addressed byte/half from a read word and zero/sign-extends it.
module mem_access_unit_load_aligner
  import mem_access_unit_pkg::*;
(
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    offset,
  input  size_e         size,
  input  logic          sext,
  output logic [DW-1:0] result
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign byte_c = rdata[{offset, 3'b000} +: 8];
  assign half_c = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    result = rdata;
    case (size)
      SIZE_B:  result = {{24{sext & byte_c[7]}}, byte_c};
      SIZE_H:  result = {{16{sext & half_c[15]}}, half_c};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one word-wide memory access per request with wait states,
// timeout abort, and aligned/extended load data back to write-back.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [1:0]     req_size,
  input  logic           req_sext,
  input  logic [AW-1:0]  req_addr,
  input  logic [DW-1:0]  req_wdata,
  output logic           mem_req,
  output logic           mem_we,
  output logic [BEW-1:0] mem_be,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ready,
  output logic           done,
  output logic           err,
  output logic [DW-1:0]  load_data
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e        state;
  req_s          r;
  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] aligned_c;
  size_e         size_c;

  assign size_c = size_e'(req_size);

  mem_access_unit_load_aligner u_align (
    .rdata  (mem_rdata),
    .offset (r.off),
    .size   (r.size),
    .sext   (r.sext),
    .result (aligned_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      r         <= '0;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r         <= '{we: req_we, size: size_c, sext: req_sext, off: req_addr[1:0]};
            req_ready <= 1'b0;
            // Illegal requests answer immediately without touching memory.
            if (bad_req(size_c, req_addr[1:0])) begin
              state <= ST_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= ST_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_be    <= lane_be(size_c, req_addr[1:0]);
              mem_addr  <= {req_addr[AW-1:2], 2'b00};
              mem_wdata <= lane_wdata(size_c, req_wdata);
            end
          end
        end
        ST_ACCESS: begin
          // mem_ready takes priority over an expiring timeout.
          if (mem_ready) begin
            state   <= ST_RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (!r.we) load_data <= aligned_c;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state   <= ST_RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          wait_cnt  <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          wait_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a lane-level reference model.
module tb_mem_access_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_sext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        done, err;
  logic [31:0] load_data;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_load = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .done(done), .err(err), .load_data(load_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_bad(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || ((a % nbytes(s)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] be = '0;
    int off = int'(a[1:0]);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nbytes(s)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(s)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic sx,
                                         input logic [31:0] a, input logic [31:0] rd);
    int          n = nbytes(s);
    logic [31:0] v, mask;
    if (n == 4) return rd;
    v    = rd >> (8 * int'(a[1:0]));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (sx && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // One request from IDLE; ready_cyc = cycle after accept on which mem_ready rises (>TO: never).
  task automatic txn(input logic we, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int ready_cyc);
    logic exp_err;
    int   c;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_sext = sx;
    req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_wdata = $urandom;
    exp_err   = m_bad(sz, a);
    if (!exp_err) begin
      exp_err = 1'b1;
      for (c = 1; c <= int'(TO); c++) begin
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_be", 32'(mem_be), 32'(m_be(sz, a)));
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_wdata", mem_wdata, m_wdata(sz, wd));
        chk("done_busy", 32'(done), 32'd0);
        mem_rdata = (c == ready_cyc) ? rd : $urandom;
        mem_ready = (c == ready_cyc);
        step();
        mem_ready = 1'b0;
        if (c == ready_cyc) begin
          exp_err = 1'b0;
          break;
        end
      end
      if (!exp_err && !we) exp_load = m_load(sz, sx, a, rd);
    end
    chk("done", 32'(done), 32'd1);
    chk("err", 32'(err), 32'(exp_err));
    chk("mem_req_resp", 32'(mem_req), 32'd0);
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    chk("load_data", load_data, exp_load);
    mem_ready = 1'b1;  // ignored outside ACCESS
    mem_rdata = $urandom;
    step();
    mem_ready = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    chk("load_data_hold", load_data, exp_load);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    step();
    rst = 1'b0;
    step();

    txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 4);
    txn(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 32'h0, 1);
    txn(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h80017FFF, 1);
    txn(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h80017FFF, 1);
    txn(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 32'h0, 1);
    txn(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 32'h0, 1);
    txn(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h12345678, 99);
    txn(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D, int'(TO));

    // Reset in the middle of an access.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h200;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    exp_load = '0;
    step();
    rst = 1'b0;
    step();
    chk("postrst_done", 32'(done), 32'd0);
    chk("postrst_mem_req", 32'(mem_req), 32'd0);
    txn(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h9A000000, 2);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(1, 18)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
